// File: rtl/dm_responder_if.sv
// Purpose : request/response bus between the M-stage data port and dm_responder.
// Latency : n/a (signal bundle only).
// Backpressure : req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
//
// Signals:
//   req_valid  / req_ready   request handshake
//   req_addr                 byte address
//   req_we                   1 = store, 0 = load
//   req_size                 0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_signed               load extension select (byte/half loads only)
//   req_wdata                store data, low-order bits used for byte/half
//   resp_valid / resp_ready  response handshake
//   resp_rdata               load result, 0 for stores and errors
//   resp_err                 misaligned, out-of-range or illegal-size access
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Requester side (pipeline M stage).
  modport master (
    output req_valid, req_addr, req_we, req_size, req_signed, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Responder side (memory).
  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_signed, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Purpose : data-memory responder; one load/store in flight, lane select, load extension, align/range checks.
// Latency : resp_valid rises exactly LATENCY edges after the accepting edge (accepting edge counts as the first).
// Backpressure : req_ready low from acceptance until the response handshake; response held stable while resp_ready = 0.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; clears state, outputs and all storage
//   bus    dm_responder_if.slave (request and response handshakes, see interface file)
module dm_responder #(
  parameter int unsigned DEPTH   = 3072,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int unsigned LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
);

  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic        LAT_1 = (LATENCY == 1);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dm_responder: LATENCY must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  // Storage words, flattened for the read mux.
  logic [DEPTH-1:0][31:0] w_words;

  logic        w_idle;
  logic [31:0] w_addr;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_signed;
  logic [31:0] w_wdata;
  logic [31:0] w_off;
  logic [31:0] w_idx;
  logic [1:0]  w_lane;
  logic        w_in_range;
  logic        w_misalign;
  logic        w_err;
  logic [IW-1:0] w_widx;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_access;
  logic        w_wr;

  // With LATENCY = 1 the access happens on the accepting edge itself, so the
  // live request fields are used in IDLE; afterwards the latched copy is used.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_addr   = w_idle ? bus.req_addr   : r_addr;
  assign w_we     = w_idle ? bus.req_we     : r_we;
  assign w_size   = w_idle ? bus.req_size   : r_size;
  assign w_signed = w_idle ? bus.req_signed : r_signed;
  assign w_wdata  = w_idle ? bus.req_wdata  : r_wdata;

  // Full 32-bit offset and index: an address below BASE wraps to a huge
  // index and is rejected by both the unsigned compare and the index bound.
  assign w_off      = w_addr - BASE;
  assign w_idx      = w_off >> 2;
  assign w_lane     = w_addr[1:0];
  assign w_in_range = (w_addr >= BASE) && (w_idx < 32'(DEPTH));
  assign w_misalign = ((w_size == 2'd1) && w_addr[0]) ||
                      ((w_size == 2'd2) && (w_addr[1:0] != 2'b00));
  assign w_err      = (w_size == 2'd3) || w_misalign || !w_in_range;
  assign w_widx     = w_idx[IW-1:0];

  assign w_old  = w_in_range ? w_words[w_widx] : 32'h0;
  assign w_byte = w_old[{w_lane, 3'b000} +: 8];
  assign w_half = w_old[{w_lane[1], 4'b0000} +: 16];

  // Read-modify-write merge of the store data into the addressed word.
  always_comb begin
    w_new = w_old;
    case (w_size)
      2'd0:    w_new[{w_lane, 3'b000} +: 8]     = w_wdata[7:0];
      2'd1:    w_new[{w_lane[1], 4'b0000} +: 16] = w_wdata[15:0];
      default: w_new = w_wdata;
    endcase
  end

  // Little-endian lane select plus sign/zero extension.
  always_comb begin
    w_load = w_old;
    case (w_size)
      2'd0:    w_load = {{24{w_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{w_signed & w_half[15]}}, w_half};
      default: w_load = w_old;
    endcase
  end

  // The access fires on the edge that enters RESP.
  assign w_access = (w_idle && bus.req_valid && LAT_1) ||
                    ((r_state == ST_WAIT) && (r_cnt == 4'd1));
  assign w_wr     = w_access && w_we && !w_err;

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= 32'h0;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_wdata      <= 32'h0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_addr      <= bus.req_addr;
            r_we        <= bus.req_we;
            r_size      <= bus.req_size;
            r_signed    <= bus.req_signed;
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            if (!LAT_1) begin
              r_cnt   <= 4'(LATENCY - 1);
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase

      if (w_access) begin
        r_state      <= ST_RESP;
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (w_err || w_we) ? 32'h0 : w_load;
      end
    end
  end

  // One register per word so every word clears on reset.
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
      logic [31:0] r_word;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_word <= 32'h0;
        end else if (w_wr && (w_widx == IW'(g))) begin
          r_word <= w_new;
        end
      end
      assign w_words[g] = r_word;
    end
  endgenerate

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_dm_responder.sv
// Purpose : self-checking bench for dm_responder at LATENCY = 1 and LATENCY = 4 against a byte-array model.
// Latency : n/a.
// Backpressure : exercised by holding resp_ready low and by back-to-back runs with resp_ready tied high.
module tb_dm_responder;
  localparam int          DEPTH = 3072;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  dm_responder_if bus_a();
  dm_responder_if bus_b();

  // Shared stimulus; sel steers the handshakes to one instance.
  logic        sel;
  logic        t_valid;
  logic        t_we;
  logic [1:0]  t_size;
  logic        t_sgn;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic        t_rr;

  assign bus_a.req_valid  = t_valid & ~sel;
  assign bus_b.req_valid  = t_valid & sel;
  assign bus_a.resp_ready = t_rr & ~sel;
  assign bus_b.resp_ready = t_rr & sel;
  assign bus_a.req_addr   = t_addr;
  assign bus_b.req_addr   = t_addr;
  assign bus_a.req_we     = t_we;
  assign bus_b.req_we     = t_we;
  assign bus_a.req_size   = t_size;
  assign bus_b.req_size   = t_size;
  assign bus_a.req_signed = t_sgn;
  assign bus_b.req_signed = t_sgn;
  assign bus_a.req_wdata  = t_wdata;
  assign bus_b.req_wdata  = t_wdata;

  logic        o_rdy, o_vld, o_err;
  logic [31:0] o_rdata;
  assign o_rdy   = sel ? bus_b.req_ready  : bus_a.req_ready;
  assign o_vld   = sel ? bus_b.resp_valid : bus_a.resp_valid;
  assign o_err   = sel ? bus_b.resp_err   : bus_a.resp_err;
  assign o_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;

  dm_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  dm_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(4)) u_lat4 (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference storage: one byte array per instance.
  logic [7:0] mem_m [2][DEPTH*4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < DEPTH*4; b++)
        mem_m[s][b] = 8'h00;
  endtask

  task automatic model(input int s, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata);
    logic [31:0] off;
    logic [31:0] v;
    int nb;
    off   = addr - BASE;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err   = (size == 2'd3) || ((addr % nb) != 0) || (addr < BASE) || ((off / 4) >= DEPTH);
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mem_m[s][off + k] = wdata[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mem_m[s][off + k];
        if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        rdata = v;
      end
    end
  endtask

  // One transaction: check acceptance, latency, response against the model,
  // hold the response for `hold` cycles, then complete the handshake.
  // Request inputs and resp_ready are scrambled while the access is pending.
  task automatic txn(input int s, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     input string tag, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n;
    int          lat;
    lat = (s == 0) ? 1 : 4;
    @(negedge clk);
    sel  = s[0];
    t_rr = 1'b0;
    check({tag, "/req_ready"}, 32'(o_rdy), 32'd1);
    t_we = we; t_size = size; t_sgn = sgn; t_addr = addr; t_wdata = wdata; t_valid = 1'b1;
    model(s, we, size, sgn, addr, wdata, exp_err, exp_rd);
    @(posedge clk); #1;
    n = 1;
    while (o_vld !== 1'b1 && n < 40) begin
      t_valid = 1'($urandom); t_we = 1'($urandom); t_size = 2'($urandom);
      t_sgn = 1'($urandom); t_addr = $urandom; t_wdata = $urandom; t_rr = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    t_valid = 1'b0;
    t_rr    = 1'b0;
    check({tag, "/latency"}, 32'(n), 32'(lat));
    check({tag, "/err"}, 32'(o_err), 32'(exp_err));
    check({tag, "/rdata"}, o_rdata, exp_rd);
    got = o_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 32'(o_vld), 32'd1);
      check({tag, "/hold_rdata"}, o_rdata, exp_rd);
      check({tag, "/hold_req_ready"}, 32'(o_rdy), 32'd0);
    end
    @(negedge clk);
    t_rr = 1'b1;
    @(posedge clk); #1;
    t_rr = 1'b0;
    check({tag, "/done_valid"}, 32'(o_vld), 32'd0);
    check({tag, "/done_req_ready"}, 32'(o_rdy), 32'd1);
  endtask

  // Alternating word store/load with req_valid and resp_ready held high.
  task automatic b2b(input int s);
    int          lat, n, acc_prev;
    logic        e;
    logic [31:0] r, a;
    lat = (s == 0) ? 1 : 4;
    acc_prev = -1;
    a = 32'h0;
    @(negedge clk);
    sel = s[0]; t_rr = 1'b1; t_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (i % 2 == 0) a = 32'($urandom_range(0, 15)) << 2;
      t_we = (i % 2 == 0); t_size = 2'd2; t_sgn = 1'b0; t_addr = a; t_wdata = $urandom;
      model(s, t_we, t_size, t_sgn, t_addr, t_wdata, e, r);
      @(posedge clk); #1;
      n = 1;
      if (acc_prev >= 0) check("b2b/period", 32'(cyc - acc_prev), 32'(lat + 1));
      acc_prev = cyc;
      while (o_vld !== 1'b1 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("b2b/latency", 32'(n), 32'(lat));
      check("b2b/err", 32'(o_err), 32'(e));
      check("b2b/rdata", o_rdata, r);
      @(posedge clk); #1;
      check("b2b/handshake", 32'(o_vld), 32'd0);
    end
    t_valid = 1'b0;
    t_rr    = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int          kind;
    reset = 1'b1; sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_size = 2'd0;
    t_sgn = 1'b0; t_addr = 32'h0; t_wdata = 32'h0; t_rr = 1'b0;
    model_clear();
    #12;
    check("reset/a_req_ready", 32'(bus_a.req_ready), 32'd1);
    check("reset/a_resp_valid", 32'(bus_a.resp_valid), 32'd0);
    check("reset/a_rdata", bus_a.resp_rdata, 32'h0);
    check("reset/a_err", 32'(bus_a.resp_err), 32'd0);
    check("reset/b_req_ready", 32'(bus_b.req_ready), 32'd1);
    check("reset/b_resp_valid", 32'(bus_b.resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Word store/load, LATENCY = 1.
    txn(0, 1, 2'd2, 0, 32'h0, 32'h1234_5678, 0, "st_word", got);
    check("st_word/rdata_zero", got, 32'h0);
    txn(0, 0, 2'd2, 0, 32'h0, 32'h0, 0, "ld_word", got);
    check("ld_word/value", got, 32'h1234_5678);

    // Byte/half stores and extension.
    txn(0, 1, 2'd0, 0, 32'h5, 32'hFFFF_FFAB, 0, "st_byte", got);
    txn(0, 1, 2'd1, 0, 32'h6, 32'h0000_8001, 0, "st_half", got);
    txn(0, 0, 2'd2, 0, 32'h4, 32'h0, 0, "ld_w4", got);
    check("ld_w4/value", got, 32'h8001_AB00);
    txn(0, 0, 2'd0, 1, 32'h5, 32'h0, 0, "ld_bs", got);
    check("ld_bs/value", got, 32'hFFFF_FFAB);
    txn(0, 0, 2'd0, 0, 32'h5, 32'h0, 0, "ld_bu", got);
    check("ld_bu/value", got, 32'h0000_00AB);
    txn(0, 0, 2'd1, 1, 32'h6, 32'h0, 0, "ld_hs", got);
    check("ld_hs/value", got, 32'hFFFF_8001);

    // Errors.
    txn(0, 0, 2'd1, 0, 32'h3, 32'h0, 0, "err_mis", got);
    txn(0, 1, 2'd2, 0, 32'(DEPTH*4), 32'hDEAD_BEEF, 0, "err_range", got);
    txn(0, 1, 2'd2, 0, 32'(DEPTH*4 - 4), 32'hCAFE_0001, 0, "last_word", got);
    txn(0, 0, 2'd2, 0, 32'h0, 32'h0, 0, "ld_after_err", got);
    check("ld_after_err/value", got, 32'h1234_5678);
    txn(0, 0, 2'd3, 0, 32'h0, 32'h0, 0, "err_size3", got);

    // LATENCY = 4 with backpressure and scrambled inputs during WAIT.
    txn(1, 1, 2'd2, 0, 32'h20, 32'hA5A5_0F0F, 3, "l4_st", got);
    txn(1, 0, 2'd2, 0, 32'h20, 32'h0, 3, "l4_ld", got);
    check("l4_ld/value", got, 32'hA5A5_0F0F);

    // Reset while a store sits in WAIT.
    txn(1, 1, 2'd2, 0, 32'h10, 32'h1111_2222, 0, "pre_rst_st", got);
    @(negedge clk);
    sel = 1'b1; t_we = 1'b1; t_size = 2'd2; t_addr = 32'h10; t_wdata = 32'h3333_4444; t_valid = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(posedge clk); #2;
    check("rst/in_wait_req_ready", 32'(o_rdy), 32'd0);
    reset = 1'b1;
    #1;
    check("rst/async_req_ready", 32'(o_rdy), 32'd1);
    check("rst/async_valid", 32'(o_vld), 32'd0);
    check("rst/async_rdata", o_rdata, 32'h0);
    check("rst/async_err", 32'(o_err), 32'd0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    txn(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, "post_rst_ld", got);
    check("post_rst_ld/value", got, 32'h0);

    // Back-to-back throughput.
    b2b(0);
    b2b(1);

    // Randomized traffic, including near/over the top of memory and huge addresses.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      if (kind <= 1)      a = 32'($urandom_range(0, 63));
      else if (kind == 2) a = 32'(DEPTH*4 - 8) + 32'($urandom_range(0, 15));
      else                a = $urandom;
      txn(i % 2, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
          $urandom_range(0, 2), "rand", got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the pipeline's data-memory port. It accepts one load or store request at a time from the M stage through a valid/ready handshake.
- It completes the access after a fixed, parameterised latency and returns read data through a second valid/ready handshake.
- It replaces the zero-latency DM array so the pipeline can be exercised against a multi-cycle memory. The core stalls on req_ready/resp_valid.
- It performs byte/half/word lane selection, load sign/zero extension, and alignment and range checking.

Parameters:
- DEPTH, 3072: number of 32-bit words of storage (12 KiB).
- BASE, 32'h00000000: byte address mapped to word 0.
- LATENCY, 1: edges from request acceptance to resp_valid rising. Legal range 1..15; 0 is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and reported as an error.
- req_signed  input  1  load extension: 1 = sign-extend, 0 = zero-extend. Ignored for word accesses and stores.
- req_wdata  input  32  store data; low-order bits are used for byte/half.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or illegal-size access.

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - All DEPTH words are cleared to 0.
  - Any in-flight transaction is abandoned; a pending store is not written.
- States:
  - IDLE: req_ready = 1. On a clock edge with req_valid = 1, latch addr/we/size/signed/wdata.
    - LATENCY = 1: go to RESP.
    - Otherwise: load counter with LATENCY-1 and go to WAIT.
  - WAIT: req_ready = 0. Decrement the counter each edge. On the edge where the counter is 1, perform the access and go to RESP.
  - RESP: resp_valid = 1, outputs stable. On an edge with resp_ready = 1, go to IDLE and drop resp_valid. Otherwise hold all outputs unchanged.
- Timing:
  - resp_valid rises exactly LATENCY edges after the accepting edge.
  - req_ready is low from the accepting edge until the response handshake completes.
  - Throughput is at most one transaction per LATENCY+1 cycles.
  - There is no request/response overlap, so there is no combinational path from req_* to resp_*.
- Access is performed on the edge that enters RESP:
  - Index = (addr - BASE) >> 2; lane = addr[1:0].
  - Error if any of the following holds:
    - size = 3;
    - size = 1 and addr[0] ≠ 0;
    - size = 2 and addr[1:0] ≠ 0;
    - addr < BASE;
    - index ≥ DEPTH.
  - On error: resp_err = 1, resp_rdata = 0, and no storage change.
  - Store, byte: write wdata[7:0] to byte lane `lane`; other bytes unchanged.
  - Store, half: write wdata[15:0] to bytes lane..lane+1.
  - Store, word: write the full word.
  - A store returns resp_rdata = 0, resp_err = 0.
  - Load: select the byte/half at the lane (little-endian: lane 0 = bits 7:0), then extend per req_signed. Word loads are returned unmodified.
- The response reflects storage contents after all earlier completed stores. This gives read-after-write ordering, because there is only one transaction in flight.
- req_* inputs are only sampled in IDLE. Changes at other times have no effect.
- resp_ready while resp_valid = 0 is ignored.
- Subtraction and index are computed at 32 bits. The range check uses an unsigned compare, so wrap-around of addr - BASE must not alias into range.

Test Plan:
1. Reset then word store/load, LATENCY = 1:
   - Store 32'h12345678 to 0x0; resp_valid after 1 edge, err = 0, rdata = 0.
   - Load 0x0 returns 32'h12345678.
2. Byte/half store and signed/unsigned load:
   - Store byte 0xAB to 0x5, then store half 0x8001 to 0x6.
   - Word load at 0x4 returns 32'h8001AB00.
   - Signed byte load at 0x5 returns 32'hFFFFFFAB; unsigned returns 32'h000000AB.
   - Signed half load at 0x6 returns 32'hFFFF8001.
3. Errors:
   - Half load at 0x3 → err = 1, rdata = 0.
   - Word store at DEPTH*4 → err = 1, and the word at 0x0 is unchanged.
   - size = 3 → err = 1.
4. Latency and backpressure, LATENCY = 4:
   - resp_valid rises exactly 4 edges after acceptance.
   - Hold resp_ready = 0 for 3 cycles; outputs stay stable and req_ready stays 0.
   - Request inputs toggled during WAIT are ignored.
5. Reset mid-transaction:
   - Assert reset during WAIT of a store to 0x10.
   - Outputs clear immediately, without waiting for a clock edge; req_ready = 1.
   - A subsequent load of 0x10 returns 0.
6. Back-to-back:
   - 10 alternating stores/loads with resp_ready tied high.
   - Each completes in LATENCY+1 cycles; load data matches a reference model.
